// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller.
// Turns a single-cycle load/store request from EX/MEM into a handshaked
// memory transaction, stalling the pipeline until the memory acknowledges
// or a wait budget expires.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-low reset
//   M_i[1:0]              {MemRead, MemWrite} from EX/MEM
//   addr_i, wdata_i       byte address (ALU result) and store data
//   rdata_o               load data toward MEM/WB
//   stall_o               freezes PC and pipeline registers (combinational)
//   err_o                 sticky access error (misaligned, 2'b11, timeout)
//   mem_req_o, mem_we_o   memory request / write enable
//   mem_addr_o            word address (byte address >> 2)
//   mem_wdata_o           store data toward memory
//   mem_ack_i             memory completion
//   mem_rdata_i           memory read data, valid with mem_ack_i
module mem_access_unit #(
  // Maximum BUSY cycles spent waiting for mem_ack_i; must be at least 1.
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  M_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // Counter only has to reach TIMEOUT_CYC-1 before the expiry edge.
  localparam int unsigned CNT_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned WADR_W = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WADR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                req_q, req_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                stall_c;

  // Request decode
  logic is_load, is_store, aligned, valid_op, illegal_op, last_wait;

  assign is_load    = (M_i == 2'b10);
  assign is_store   = (M_i == 2'b01);
  assign aligned    = (addr_i[1:0] == 2'b00);
  assign valid_op   = (is_load || is_store) && aligned;
  assign illegal_op = (M_i == 2'b11) || ((is_load || is_store) && !aligned);
  // This BUSY cycle is the last one allowed without an ack.
  assign last_wait  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_op) begin
          // Stall now so the instruction stays in EX/MEM while we latch it.
          stall_c = 1'b1;
          state_d = BUSY;
          cnt_d   = '0;
          waddr_d = addr_i[31:2];
          wdata_d = wdata_i;
          we_d    = is_store;
          req_d   = 1'b1;
        end else if (illegal_op) begin
          err_d = 1'b1;
        end
      end

      BUSY: begin
        stall_c = 1'b1;
        // Ack takes priority over an expiring wait budget.
        if (mem_ack_i) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) begin
            rdata_d = mem_rdata_i;
          end
        end else if (last_wait) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          if (!we_q) begin
            rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Pipeline advances on this edge; the stalled instruction leaves EX/MEM.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = {2'b00, waddr_q};
  assign mem_wdata_o = wdata_q;
  // Gate with reset so a valid request on M_i cannot stall during reset.
  assign stall_o     = rst_i && stall_c;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: main instance with a 16-cycle wait
// budget plus a second instance with a 4-cycle budget sharing the inputs.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  M_i;
  logic [31:0] addr_i, wdata_i, mem_rdata_i;
  logic        mem_ack_i;

  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic        stall_o, err_o, mem_req_o, mem_we_o;

  logic [31:0] t4_rdata, t4_addr, t4_wdata;
  logic        t4_stall, t4_err, t4_req, t4_we;

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.TIMEOUT_CYC(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .M_i(M_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  mem_access_unit #(.TIMEOUT_CYC(4)) dut_t4 (
    .clk_i(clk_i), .rst_i(rst_i), .M_i(M_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(t4_rdata), .stall_o(t4_stall), .err_o(t4_err), .mem_req_o(t4_req),
    .mem_we_o(t4_we), .mem_addr_o(t4_addr), .mem_wdata_o(t4_wdata),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          issues = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  // Count request issues on the main instance.
  always @(posedge mem_req_o) issues++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the DUT in IDLE; ends at the negedge of the
  // following IDLE cycle. ack_at is the BUSY cycle carrying the ack.
  task automatic run_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rd);
    exp_t e, got;
    int   issued0;
    int   nstall;
    issued0 = issues;
    nstall  = 0;
    M_i = m; addr_i = a; wdata_i = wd; mem_ack_i = 1'b0;
    e.rdata = (m == 2'b10) ? rd : exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    #1;
    check("idle_stall", 32'(stall_o), 32'd1);
    check("idle_req", 32'(mem_req_o), 32'd0);
    if (stall_o) nstall++;
    for (int k = 1; k <= ack_at; k++) begin
      @(negedge clk_i);
      check("busy_req", 32'(mem_req_o), 32'd1);
      check("busy_we", 32'(mem_we_o), 32'(m == 2'b01));
      check("busy_addr", mem_addr_o, a >> 2);
      check("busy_wdata", mem_wdata_o, wd);
      if (stall_o) nstall++;
      mem_ack_i   = (k == ack_at);
      mem_rdata_i = (k == ack_at) ? rd : (32'hBAD0_0000 | 32'(k));
    end
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    check("done_stall", 32'(stall_o), 32'd0);
    check("done_req", 32'(mem_req_o), 32'd0);
    check("stall_len", 32'(nstall), 32'(ack_at + 1));
    check("issue_once", 32'(issues), 32'(issued0 + 1));
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check("done_rdata", rdata_o, got.rdata);
      check("done_err", 32'(err_o), 32'(got.err));
      exp_rdata = got.rdata;
    end
    @(negedge clk_i);
    M_i = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    M_i = 2'b00; mem_ack_i = 1'b0;
    #2;
    rst_i = 1'b1;
    exp_rdata = '0;
    exp_err = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    int issued0;
    rst_i = 1'b0;
    M_i = 2'b10; addr_i = 32'h10; wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    #2;
    // Reset values, with a valid request present on M_i.
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_we", 32'(mem_we_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_wdata", mem_wdata_o, 32'd0);
    #10;
    M_i = 2'b00;
    rst_i = 1'b1;
    @(negedge clk_i);

    // Load, ack in first BUSY cycle.
    run_op(2'b10, 32'h10, 32'h0, 1, 32'hDEADBEEF);

    // Ack on the same edge the 4-cycle budget expires: ack wins.
    run_op(2'b10, 32'h50, 32'h0, 4, 32'hCAFEF00D);
    check("t4_race_err", 32'(t4_err), 32'd0);
    check("t4_race_rdata", t4_rdata, 32'hCAFEF00D);

    // Back-to-back load then store.
    run_op(2'b10, 32'h30, 32'h0, 1, 32'hA5A50001);
    run_op(2'b01, 32'h34, 32'h0BADCAFE, 1, 32'h77777777);

    // Store with ack in the fifth BUSY cycle.
    run_op(2'b01, 32'h20, 32'h12345678, 5, 32'h55555555);

    // Ack while idle is ignored.
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
    issued0 = issues;
    repeat (2) @(negedge clk_i);
    mem_ack_i = 1'b0;
    check("idle_ack_rdata", rdata_o, exp_rdata);
    check("idle_ack_req", 32'(mem_req_o), 32'd0);
    check("idle_ack_err", 32'(err_o), 32'd0);
    check("idle_ack_issue", 32'(issues), 32'(issued0));

    // Misaligned load, then M_i=2'b11.
    M_i = 2'b10; addr_i = 32'h22;
    #1;
    check("misal_stall", 32'(stall_o), 32'd0);
    check("misal_err_pre", 32'(err_o), 32'd0);
    @(negedge clk_i);
    check("misal_err", 32'(err_o), 32'd1);
    check("misal_req", 32'(mem_req_o), 32'd0);
    M_i = 2'b11; addr_i = 32'h40;
    #1;
    check("m11_stall", 32'(stall_o), 32'd0);
    @(negedge clk_i);
    M_i = 2'b00;
    check("m11_req", 32'(mem_req_o), 32'd0);
    @(negedge clk_i);
    check("err_sticky", 32'(err_o), 32'd1);
    check("illegal_issue", 32'(issues), 32'(issued0));

    // Timeout on the 4-cycle instance.
    do_reset();
    run_op(2'b10, 32'h60, 32'h0, 1, 32'h11112222);
    M_i = 2'b10; addr_i = 32'h64;
    #1;
    check("to_stall_idle", 32'(t4_stall), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      check("to_busy_req", 32'(t4_req), 32'd1);
      check("to_busy_stall", 32'(t4_stall), 32'd1);
    end
    @(negedge clk_i);
    check("to_done_req", 32'(t4_req), 32'd0);
    check("to_done_err", 32'(t4_err), 32'd1);
    check("to_done_rdata", t4_rdata, 32'd0);
    check("to_done_stall", 32'(t4_stall), 32'd0);
    M_i = 2'b00;
    @(negedge clk_i);
    check("to_idle_stall", 32'(t4_stall), 32'd0);
    check("to_idle_req", 32'(t4_req), 32'd0);
    check("to_idle_err", 32'(t4_err), 32'd1);

    // Reset in the second BUSY cycle of a load.
    do_reset();
    issued0 = issues;
    M_i = 2'b10; addr_i = 32'h70;
    @(negedge clk_i);
    check("abort_busy1", 32'(mem_req_o), 32'd1);
    @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check("abort_req", 32'(mem_req_o), 32'd0);
    check("abort_stall", 32'(stall_o), 32'd0);
    check("abort_rdata", rdata_o, 32'd0);
    M_i = 2'b00;
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h99999999;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    check("late_ack_req", 32'(mem_req_o), 32'd0);
    check("late_ack_rdata", rdata_o, 32'd0);
    check("late_ack_stall", 32'(stall_o), 32'd0);
    check("late_ack_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    check("no_reissue", 32'(issues), 32'(issued0 + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

endmodule
